// File: rtl/coco_timer.sv
// coco_timer: memory-mapped countdown timer with one-shot and auto-reload modes.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module coco_timer #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    logic        tick;
    logic        ctrl_we;
    logic        preset_we;
    logic        auto_mode;
    logic        count_last;

    generate
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("coco_timer: PRESCALE out of range 1..65535");
        end
    endgenerate

    assign ctrl_we    = WE && (Addr == 2'd0);
    assign preset_we  = WE && (Addr == 2'd1);
    assign auto_mode  = (ctrl[2:1] == 2'b01);
    assign count_last = (count <= 32'd1);

`ifdef TIMER_PRESCALE_EN
    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc;

    assign tick = (presc == PS_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            presc <= '0;
        end else if (state == S_LOAD) begin
            presc <= '0;
        end else if (state == S_CNT && ctrl[0]) begin
            presc <= tick ? 16'd0 : presc + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (ctrl[0]) state_n = S_LOAD;
            S_LOAD: state_n = S_CNT;
            S_CNT: begin
                if (!ctrl[0])
                    state_n = S_IDLE;
                else if (tick && count_last)
                    state_n = S_INT;
            end
            S_INT: state_n = auto_mode ? S_LOAD : S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // A CPU write on the same edge as the hardware Enable clear takes priority.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ctrl <= '0;
        end else if (ctrl_we) begin
            ctrl <= DIN[3:0];
        end else if (state == S_INT && !auto_mode) begin
            ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            preset <= '0;
        else if (preset_we)
            preset <= DIN;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (state == S_LOAD) begin
            count <= preset;
        end else if (state == S_CNT && ctrl[0] && tick) begin
            count <= count_last ? 32'd0 : count - 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            irq_flag <= 1'b0;
        else if (ctrl_we || preset_we)
            irq_flag <= 1'b0;
        else if (state == S_INT)
            irq_flag <= 1'b1;
        else if (state == S_LOAD)
            irq_flag <= 1'b0;
    end

    assign IRQ = ctrl[3] & irq_flag;

    always_comb begin
        DOUT = '0;
        unique case (Addr)
            2'd0: DOUT = {28'd0, ctrl};
            2'd1: DOUT = preset;
            2'd2: DOUT = count;
            2'd3: DOUT = '0;
        endcase
    end

endmodule

// File: tb/tb_coco_timer.sv
// Randomized scoreboard bench for coco_timer against an elapsed-time reference model.
// Build with +define+TIMER_PRESCALE_EN to exercise the prescaled variant.
module tb_coco_timer;

    localparam int unsigned PS_CFG = 4;
`ifdef TIMER_PRESCALE_EN
    localparam longint PS = PS_CFG;
`else
    localparam longint PS = 1;
`endif

    logic        Clk;
    logic        Reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        IRQ;

    coco_timer #(.PRESCALE(PS_CFG)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Addr  (Addr),
        .WE    (WE),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .IRQ   (IRQ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timer phases with count derived from elapsed run cycles.
    typedef enum {P_OFF, P_ARM, P_RUN, P_FIRE} phase_t;
    phase_t      ph;
    logic        m_en;
    logic [1:0]  m_mode;
    logic        m_im;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    longint      m_p;
    longint      m_k;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] dout;
        logic        irq;
    } exp_t;
    exp_t q[$];

    task automatic model_reset();
        ph = P_OFF;
        m_en = 0; m_mode = 0; m_im = 0;
        m_preset = 0; m_count = 0; m_flag = 0;
        m_p = 1; m_k = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return {28'd0, m_im, m_mode, m_en};
            2'd1: return m_preset;
            2'd2: return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d);
        phase_t      nph = ph;
        logic        nen = m_en;
        logic [31:0] ncount = m_count;
        logic        nflag = m_flag;
        longint      done;
        case (ph)
            P_OFF: if (m_en) nph = P_ARM;
            P_ARM: begin
                ncount = m_preset;
                m_p = (m_preset == 0) ? 1 : longint'(m_preset);
                m_k = 0;
                nflag = 0;
                nph = P_RUN;
            end
            P_RUN: begin
                if (!m_en) begin
                    nph = P_OFF;
                end else begin
                    m_k++;
                    if (m_k % PS == 0) begin
                        done = m_k / PS;
                        if (done >= m_p) begin
                            ncount = 0;
                            nph = P_FIRE;
                        end else begin
                            ncount = 32'(m_p - done);
                        end
                    end
                end
            end
            P_FIRE: begin
                nflag = 1;
                if (m_mode == 2'b01) begin
                    nph = P_ARM;
                end else begin
                    nen = 0;
                    nph = P_OFF;
                end
            end
        endcase
        if (we && a == 2'd0) begin
            nen = d[0]; m_mode = d[2:1]; m_im = d[3]; nflag = 0;
        end
        if (we && a == 2'd1) begin
            m_preset = d; nflag = 0;
        end
        ph = nph; m_en = nen; m_count = ncount; m_flag = nflag;
    endtask

    // One bus cycle: drive at negedge, step model at posedge, queue expectation.
    task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge Clk);
        WE = we; Addr = a; DIN = d;
        @(posedge Clk);
        model_edge(we, a, d);
        e.addr = a;
        e.dout = model_read(a);
        e.irq = m_im & m_flag;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("irq", IRQ, e.irq);
                check($sformatf("dout[a%0d]", e.addr), DOUT, e.dout);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'd2, $urandom);
    endtask

    task automatic latency(input string name, input longint exp);
        int n = 0;
        do begin
            step(0, 2'd2, 0);
            n++;
            #2;
        end while (!IRQ && n < 400);
        check(name, n, exp);
    endtask

    task automatic do_reset(input string name);
        #3;
        Reset = 1'b0;
        #1;
        check({name, "_irq"}, IRQ, 0);
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a);
            #1;
            check($sformatf("%s_dout%0d", name, a), DOUT, 0);
        end
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin : stim
        int guard;
        logic [1:0] a;
        logic [31:0] d;
        model_reset();
        WE = 0; Addr = 0; DIN = 0;
        Reset = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            Addr = 2'(i);
            #1;
            check($sformatf("rst_dout%0d", i), DOUT, 0);
        end
        check("rst_irq", IRQ, 0);
        #10;
        Reset = 1'b1;

        // One-shot: sticky IRQ, COUNT 0, Enable self-clears.
        step(1, 2'd1, 5);
        step(1, 2'd0, 32'h9);
        latency("oneshot_lat", 2 + 5 * PS + 1);
        idle(6);
        check("oneshot_sticky", IRQ, 1);
        step(0, 2'd0, 0);
        step(1, 2'd0, 32'h8);
        idle(2);

        // Auto-reload pulses, then stop.
        step(1, 2'd1, 3);
        step(1, 2'd0, 32'hB);
        idle(int'(4 * (3 * PS + 2)));
        step(1, 2'd0, 32'h8);
        idle(8);

        // Masked interrupt, then unmask by write without counting.
        step(1, 2'd1, 2);
        step(1, 2'd0, 32'h1);
        idle(int'(2 * PS + 6));
        step(1, 2'd0, 32'h8);
        idle(3);

        // Pause at COUNT=6, new PRESET, re-enable reloads.
        step(1, 2'd1, 10);
        step(1, 2'd0, 32'h9);
        guard = 0;
        while (m_count != 6 && guard < 200) begin
            step(0, 2'd2, 0);
            guard++;
        end
        check("pause_reached", guard < 200, 1);
        step(1, 2'd0, 32'h8);
        idle(3);
        step(1, 2'd1, 4);
        step(0, 2'd2, 0);
        step(1, 2'd0, 32'h9);
        latency("reenable_lat", 2 + 4 * PS + 1);
        idle(2);

        // Async reset with IRQ high, and mid-count with COUNT=7.
        do_reset("rst_irq_hi");
        step(1, 2'd1, 20);
        step(1, 2'd0, 32'h9);
        guard = 0;
        while (m_count != 7 && guard < 200) begin
            step(0, 2'd2, 0);
            guard++;
        end
        check("count7_reached", guard < 200, 1);
        do_reset("rst_mid");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) begin
                if (a == 2'd1)
                    d = $urandom_range(0, 8);
                else if (a == 2'd0)
                    d = {$urandom, 1'b0} | 32'($urandom_range(0, 3) != 0);
                else
                    d = $urandom;
                step(1, a, d);
            end else begin
                step(0, a, $urandom);
            end
        end

        @(posedge Clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
